// File: rtl/prm_edge_mask_scan.sv
// Frame sequencer for the PRM obstacle checker bank: folds per-code edge masks
// into a blocked-edge bitmap, then streams the bitmap out word by word with a popcount.
module prm_edge_mask_scan #(
  parameter int CODE_W    = 15,
  parameter int NUM_EDGES = 512,
  parameter int WORD_W    = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   obs_valid,
  output logic                                   obs_ready,
  input  logic [CODE_W-1:0]                      obs_code,
  input  logic                                   obs_last,
  output logic [CODE_W-1:0]                      chk_code,
  output logic                                   chk_vld,
  input  logic [NUM_EDGES-1:0]                   chk_mask,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [WORD_W-1:0]                      out_data,
  output logic [$clog2(NUM_EDGES/WORD_W)-1:0]    out_idx,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done,
  output logic [$clog2(NUM_EDGES+1)-1:0]         blocked_cnt
);
  localparam int NUM_WORDS = NUM_EDGES / WORD_W;
  localparam int IDX_W     = $clog2(NUM_WORDS);
  localparam int CNT_W     = $clog2(NUM_EDGES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_e;

  state_e                             state_q, state_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0]   bitmap_q, bitmap_d;
  logic [CODE_W-1:0]                  chk_code_q, chk_code_d;
  logic                               chk_vld_q, chk_vld_d;
  logic                               chk_last_q, chk_last_d;
  logic                               last_acc_q, last_acc_d;
  logic [IDX_W-1:0]                   out_idx_q, out_idx_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [CNT_W-1:0]                   blocked_cnt_q, blocked_cnt_d;
  logic                               done_q, done_d;

  logic              obs_hs, out_hs, is_last_word;
  logic [WORD_W-1:0] cur_word;
  logic [CNT_W-1:0]  word_pop;

  function automatic logic [CNT_W-1:0] popcnt(input logic [WORD_W-1:0] w);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < WORD_W; i++) s = s + CNT_W'(w[i]);
    return s;
  endfunction

  assign cur_word     = bitmap_q[out_idx_q];
  assign word_pop     = popcnt(cur_word);
  assign is_last_word = (out_idx_q == IDX_W'(NUM_WORDS - 1));
  assign obs_hs       = obs_valid & obs_ready;
  assign out_hs       = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM;
      S_ACCUM: if (chk_vld_q && chk_last_q) state_d = S_DRAIN;
      S_DRAIN: if (out_hs && is_last_word) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    obs_ready = (state_q == S_ACCUM) && !last_acc_q;
    out_valid = (state_q == S_DRAIN);
    busy      = (state_q != S_IDLE);
  end

  // Datapath next-state
  always_comb begin
    bitmap_d      = bitmap_q;
    chk_code_d    = chk_code_q;
    chk_vld_d     = 1'b0;
    chk_last_d    = 1'b0;
    last_acc_d    = last_acc_q;
    out_idx_d     = out_idx_q;
    cnt_d         = cnt_q;
    blocked_cnt_d = blocked_cnt_q;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bitmap_d   = '0;
          cnt_d      = '0;
          last_acc_d = 1'b0;
          out_idx_d  = '0;
        end
      end
      S_ACCUM: begin
        if (obs_hs) begin
          chk_code_d = obs_code;
          chk_vld_d  = 1'b1;
          chk_last_d = obs_last;
          if (obs_last) last_acc_d = 1'b1;
        end
        // Mask is the checker response to the code registered last cycle
        if (chk_vld_q) bitmap_d = bitmap_q | chk_mask;
      end
      S_DRAIN: begin
        if (out_hs) begin
          cnt_d = cnt_q + word_pop;
          if (is_last_word) begin
            blocked_cnt_d = cnt_q + word_pop;
            done_d        = 1'b1;
            out_idx_d     = '0;
          end else begin
            out_idx_d = out_idx_q + IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_q      <= '0;
      chk_code_q    <= '0;
      chk_vld_q     <= 1'b0;
      chk_last_q    <= 1'b0;
      last_acc_q    <= 1'b0;
      out_idx_q     <= '0;
      cnt_q         <= '0;
      blocked_cnt_q <= '0;
      done_q        <= 1'b0;
    end else begin
      bitmap_q      <= bitmap_d;
      chk_code_q    <= chk_code_d;
      chk_vld_q     <= chk_vld_d;
      chk_last_q    <= chk_last_d;
      last_acc_q    <= last_acc_d;
      out_idx_q     <= out_idx_d;
      cnt_q         <= cnt_d;
      blocked_cnt_q <= blocked_cnt_d;
      done_q        <= done_d;
    end
  end

  assign chk_code    = chk_code_q;
  assign chk_vld     = chk_vld_q;
  assign out_data    = cur_word;
  assign out_idx     = out_idx_q;
  assign out_last    = out_valid && is_last_word;
  assign done        = done_q;
  assign blocked_cnt = blocked_cnt_q;

endmodule

// File: tb/tb_prm_edge_mask_scan.sv
// Randomized frame-level bench for prm_edge_mask_scan; the checker bank is a mask
// lookup table keyed by the low code bits, and the expected bitmap is the OR of looked-up masks.
module tb_prm_edge_mask_scan;
  localparam int CODE_W = 15, NE = 512, WW = 32, NW = NE / WW;

  logic clk = 1'b0, rst, start, obs_valid, obs_ready, obs_last;
  logic [CODE_W-1:0] obs_code, chk_code;
  logic chk_vld, out_valid, out_ready, out_last, busy, done;
  logic [NE-1:0] chk_mask;
  logic [WW-1:0] out_data;
  logic [3:0] out_idx;
  logic [9:0] blocked_cnt;

  logic [NE-1:0] mask_tbl [16];
  logic [NE-1:0] exp_bm;
  int codes[$];
  int errors = 0, checks = 0, prev_cnt = 0, vld_cnt = 0;

  always #5 clk = ~clk;

  // Checker bank model; noise when no live query so stray folds are visible
  assign chk_mask = chk_vld ? mask_tbl[chk_code[3:0]] : {16{32'hA5A55A5A}};

  always @(posedge clk) if (chk_vld === 1'b1) vld_cnt <= vld_cnt + 1;

  prm_edge_mask_scan #(.CODE_W(CODE_W), .NUM_EDGES(NE), .WORD_W(WW)) dut (
    .clk(clk), .rst(rst), .start(start), .obs_valid(obs_valid), .obs_ready(obs_ready),
    .obs_code(obs_code), .obs_last(obs_last), .chk_code(chk_code), .chk_vld(chk_vld),
    .chk_mask(chk_mask), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done), .blocked_cnt(blocked_cnt));

  task automatic chk(input string tag, input logic [NE-1:0] obs, input logic [NE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_obs_ready", obs_ready, 1);
  endtask

  // Present codes; start_at >= 0 also pulses start alongside that code (must be ignored)
  task automatic feed(input bit gaps, input int start_at);
    logic [CODE_W-1:0] c;
    int v0, t;
    exp_bm = '0;
    v0 = vld_cnt;
    for (int k = 0; k < codes.size(); k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          obs_valid = 1'b0; obs_code = CODE_W'($urandom); obs_last = 1'($urandom);
          @(negedge clk);
        end
      end
      c = CODE_W'($urandom);
      c[3:0] = 4'(codes[k]);
      obs_valid = 1'b1; obs_code = c; obs_last = (k == codes.size() - 1);
      start = (k == start_at);
      chk("obs_ready_accum", obs_ready, 1);
      exp_bm = exp_bm | mask_tbl[codes[k]];
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      chk("chk_vld_latency", chk_vld, 1);
      chk("chk_code", chk_code, c);
    end
    obs_valid = 1'b0; obs_last = 1'b0;
    chk("obs_ready_after_last", obs_ready, 0);
    t = 0;
    while (out_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    chk("drain_entry", out_valid, 1);
    chk("chk_vld_count", vld_cnt - v0, codes.size());
  endtask

  // mode 0: ready always; 1: ready 1,0,0 repeating; 2: random. abort_at: reset at that index.
  task automatic drain(input int mode, input int abort_at, input bit restart);
    int ei, cyc;
    bit rdy;
    ei = 0; cyc = 0;
    while (ei < NW && cyc < 400) begin
      if (ei == abort_at) begin
        rst = 1'b1; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_chk_vld", chk_vld, 0);
        chk("rst_blocked_cnt", blocked_cnt, 0);
        prev_cnt = 0;
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom);
      endcase
      out_ready = rdy;
      chk("out_valid", out_valid, 1);
      chk("out_idx", out_idx, ei);
      chk("out_data", out_data, exp_bm[ei*WW +: WW]);
      chk("out_last", out_last, (ei == NW - 1));
      chk("done_in_drain", done, 0);
      chk("blocked_cnt_held", blocked_cnt, prev_cnt);
      @(posedge clk); @(negedge clk);
      if (rdy) ei++;
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_timeout", ei, NW);
    chk("done_pulse", done, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_out_idx", out_idx, 0);
    chk("blocked_cnt", blocked_cnt, $countones(exp_bm));
    prev_cnt = $countones(exp_bm);
    start = restart;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 0; obs_valid = 0; obs_last = 0; obs_code = '0; out_ready = 0;
    mask_tbl[0] = '0; mask_tbl[0][3] = 1'b1; mask_tbl[0][40] = 1'b1;
    mask_tbl[1] = NE'(1); mask_tbl[2] = NE'(2); mask_tbl[3] = NE'(4);
    mask_tbl[8] = '1;
    for (int m = 4; m < 16; m++) begin
      if (m == 8) continue;
      for (int w = 0; w < NW; w++) mask_tbl[m][w*WW +: WW] = $urandom & $urandom;
    end
    repeat (3) @(negedge clk);
    chk("reset_obs_ready", obs_ready, 0);
    chk("reset_chk_vld", chk_vld, 0);
    chk("reset_chk_code", chk_code, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_idx", out_idx, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_blocked_cnt", blocked_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_obs_ready", obs_ready, 0);

    // single code, bits 3 and 40
    codes = {0}; do_start(); feed(0, -1); drain(0, -1, 0);
    // three back-to-back codes -> word0 = 7
    codes = {1, 2, 3}; do_start(); feed(0, -1); drain(0, -1, 0);
    // random codes, stalled drain 1,0,0
    codes = '{};
    repeat (5) codes.push_back($urandom_range(4, 7));
    do_start(); feed(1, -1); drain(1, -1, 0);
    // all ones, then restart in the done cycle
    codes = {8}; do_start(); feed(0, -1); drain(2, -1, 1);
    // second frame, start pulsed mid-accumulation
    codes = '{};
    repeat (6) codes.push_back($urandom_range(9, 15));
    feed(1, 2); drain(2, -1, 0);
    // reset in the middle of drain, then a clean frame
    codes = '{};
    repeat (3) codes.push_back($urandom_range(4, 15));
    do_start(); feed(0, -1); drain(0, 5, 0);
    codes = {9}; do_start(); feed(0, -1); drain(0, -1, 0);
    // random frames
    for (int f = 0; f < 3; f++) begin
      codes = '{};
      repeat ($urandom_range(1, 6)) codes.push_back($urandom_range(0, 15));
      do_start(); feed(1, -1); drain(2, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/prm_edge_mask_scan.md
Name: prm_edge_mask_scan

Overview:
- Frame-level sequencer that drives obstacle configuration codes into the bank of per-edge PRM obstacle checkers and collects their edge_mask results.
- For each obstacle code it receives, it presents the code to the combinational checker bank and ORs the returned per-edge mask vector into a blocked-edge bitmap.
- At end of frame it streams the bitmap out word-by-word to the roadmap graph-search stage, with a blocked-edge count.

Parameters:
- CODE_W, 15, width of obstacle configuration code (checker inputs A..O, A = bit 0).
- NUM_EDGES, 512, number of roadmap edges / checker instances; must be a multiple of WORD_W.
- WORD_W, 32, output bitmap word width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin frame; honoured only in IDLE.
- obs_valid  in  1  obstacle code valid.
- obs_ready  out  1  block accepts obstacle code.
- obs_code  in  CODE_W  obstacle configuration code.
- obs_last  in  1  final code of frame; qualified by obs_valid.
- chk_code  out  CODE_W  registered code driven to checker bank.
- chk_vld  out  1  chk_code is a live query this cycle.
- chk_mask  in  NUM_EDGES  combinational edge_mask vector returned for chk_code; bit e = edge e.
- out_valid  out  1  bitmap word valid.
- out_ready  in  1  downstream accepts word.
- out_data  out  WORD_W  bitmap word; bit i = edge out_idx*WORD_W+i, 1 = blocked.
- out_idx  out  clog2(NUM_EDGES/WORD_W)  word index.
- out_last  out  1  final word of frame.
- busy  out  1  high in ACCUM or DRAIN.
- done  out  1  one-cycle pulse on frame completion.
- blocked_cnt  out  clog2(NUM_EDGES+1)  number of blocked edges in last completed frame.

Behaviour:
- Reset: state IDLE; bitmap, chk_code, out_idx and blocked_cnt = 0; obs_ready, chk_vld, out_valid, out_last, busy and done = 0. Reset mid-frame aborts the frame immediately. No partial words are emitted.
- States: IDLE, ACCUM, DRAIN.
- IDLE: obs_ready = 0. On start=1: clear bitmap, clear running count, go to ACCUM next cycle. start is ignored in ACCUM and DRAIN.
- ACCUM:
  - obs_ready = 1 until the obs_last handshake; 0 from the cycle after that handshake.
  - Handshake is obs_valid&obs_ready. On handshake, chk_code <= obs_code and chk_vld <= 1 next cycle; otherwise chk_vld <= 0.
  - The block sustains one code per cycle.
  - In any cycle with chk_vld=1: bitmap <= bitmap | chk_mask, sampled on that clock edge.
  - When the folded query is the one tagged last, go to DRAIN next cycle.
  - A frame always contains at least one code.
- Latency: one cycle from obs handshake to chk_vld; mask folded on that same chk_vld edge.
- DRAIN:
  - out_valid = 1, out_data = bitmap word out_idx, starting at out_idx = 0.
  - out_last = 1 when out_idx = NUM_EDGES/WORD_W - 1.
  - On out_valid&out_ready: running count += popcount(out_data), out_idx increments.
  - While out_ready = 0, out_data, out_idx and out_last are held stable.
  - On the last-word handshake: blocked_cnt <= final count, done = 1 for the next cycle, go to IDLE, out_idx = 0.
- blocked_cnt holds its value until the next frame completes; it is not cleared by start.
- Back-to-back frames: start may be asserted in the cycle done is high (state IDLE). The new frame begins the cycle after.
- Upstream obs_valid during IDLE/DRAIN is not accepted (obs_ready = 0).

Test Plan:
- Single code, chk_mask bits 3 and 40 set, out_ready=1 -> 16 words; word0=0x00000008, word1=0x00000100, rest 0; out_last on idx 15; blocked_cnt=2; done pulse 1 cycle after the idx-15 handshake.
- Three back-to-back codes (obs_last on 3rd), masks 0x1, 0x2, 0x4 in word 0 -> word0=0x00000007; obs_ready drops the cycle after the 3rd handshake; chk_vld high exactly 3 consecutive cycles.
- Drain with out_ready toggling 1,0,0,1... -> out_data and out_idx stable during stalls; each idx 0..15 appears exactly once on a handshake.
- All-ones chk_mask -> every word 0xFFFFFFFF; blocked_cnt=512.
- rst asserted mid-DRAIN at out_idx=5 -> next cycle out_valid=0, busy=0, out_idx=0; a new start then accepts a frame and produces a clean bitmap.
- start pulsed during ACCUM -> ignored (bitmap not cleared); second frame started in the cycle done=1 -> accepted, and blocked_cnt from frame 1 is held until frame 2 completes.
